// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the processor core and a
//   loader port. A registered IDLE/CORE/LD state decides the owner for the
//   coming cycle from the requests sampled at the edge. Grants decode that
//   state, so the first transfer arrives one cycle after the request.
//
//   Default build: the core has fixed priority. A 4-bit starvation counter
//   forces a single loader slot once the loader has waited STARVE_MAX cycles.
//   Build with DMEM_ARB_RR_EN defined: a simple round-robin between the two
//   ports replaces the priority logic and the counter.
//
// Ports
//   i_clk, i_rst                 clock (rising edge), async active-high reset
//   i_core_req/we/addr/wdata     core request; held until transferred
//   o_core_gnt                   core owns the memory this cycle
//   o_core_rdata                 memory read data for the core
//   o_core_stall                 core_req & ~core_gnt
//   i_ld_req/we/addr/wdata       loader request; held until transferred
//   o_ld_gnt, o_ld_rdata         loader grant and read data
//   o_mem_we/addr/wdata          memory command, driven by the granted port
//   i_mem_rdata                  memory read data (combinational on address)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_core_req,
    input  logic          i_core_we,
    input  logic [AW-1:0] i_core_addr,
    input  logic [DW-1:0] i_core_wdata,
    output logic          o_core_gnt,
    output logic [DW-1:0] o_core_rdata,
    output logic          o_core_stall,
    input  logic          i_ld_req,
    input  logic          i_ld_we,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [DW-1:0] i_ld_wdata,
    output logic          o_ld_gnt,
    output logic [DW-1:0] o_ld_rdata,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CORE = 2'd1,
        S_LD   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_core_gnt;
    logic   r_ld_gnt;

`ifdef DMEM_ARB_RR_EN
    // 1 = loader was the most recent owner; reset value lets the core win the first tie
    logic r_last_ld;

    // Next owner: the port not served most recently wins a tie
    always_comb begin
        w_next = S_IDLE;
        if (i_core_req && i_ld_req) begin
            w_next = r_last_ld ? S_CORE : S_LD;
        end else if (i_core_req) begin
            w_next = S_CORE;
        end else if (i_ld_req) begin
            w_next = S_LD;
        end else begin
            w_next = S_IDLE;
        end
    end

    // Remember which port was granted last; IDLE keeps the previous owner
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_ld <= 1'b1;
        end else if (w_next == S_CORE) begin
            r_last_ld <= 1'b0;
        end else if (w_next == S_LD) begin
            r_last_ld <= 1'b1;
        end else begin
            r_last_ld <= r_last_ld;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] r_wait;
    logic       w_force_ld;

    // Next owner: core first, unless the loader has starved. The counter still
    // reads saturated during the forced LD cycle, so LD state is excluded to
    // keep the forced slot to exactly one cycle.
    always_comb begin
        w_next     = S_IDLE;
        w_force_ld = i_ld_req && (r_wait == STARVE_LIM) && (r_state != S_LD);
        if (w_force_ld) begin
            w_next = S_LD;
        end else if (i_core_req) begin
            w_next = S_CORE;
        end else if (i_ld_req) begin
            w_next = S_LD;
        end else begin
            w_next = S_IDLE;
        end
    end

    // Loader starvation counter: counts waiting cycles, saturates, clears on grant
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait <= 4'd0;
        end else if (r_ld_gnt) begin
            r_wait <= 4'd0;
        end else if (i_ld_req && (r_wait != STARVE_LIM)) begin
            r_wait <= r_wait + 4'd1;
        end else begin
            r_wait <= r_wait;
        end
    end
`endif

    // Arbitration FSM with registered grant flags decoded from the next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_core_gnt <= 1'b0;
            r_ld_gnt   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_core_gnt <= (w_next == S_CORE);
            r_ld_gnt   <= (w_next == S_LD);
        end
    end

    // Memory command mux; a granted port that dropped its request never writes
    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (r_core_gnt) begin
            o_mem_we    = i_core_req && i_core_we && !i_rst;
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
        end else if (r_ld_gnt) begin
            o_mem_we    = i_ld_req && i_ld_we && !i_rst;
            o_mem_addr  = i_ld_addr;
            o_mem_wdata = i_ld_wdata;
        end else begin
            o_mem_we    = 1'b0;
            o_mem_addr  = '0;
            o_mem_wdata = '0;
        end
    end

    assign o_core_gnt   = r_core_gnt;
    assign o_ld_gnt     = r_ld_gnt;
    assign o_core_stall = i_core_req && !r_core_gnt;
    assign o_core_rdata = i_mem_rdata;
    assign o_ld_rdata   = i_mem_rdata;

endmodule
